apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_pkg.sv | 16 +
 rtl/apb_master.sv | 122 ++++++++++++
 tb/tb_apb_master.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester: FSM state encoding and default widths.
package apb_pkg;

  localparam int APB_DATA_WIDTH     = 32;
  localparam int APB_ADDR_WIDTH     = 32;
  localparam int APB_TIMEOUT_CYCLES = 16;
  localparam int APB_TMO_CNT_W      = 16;  // covers the full 1..65535 watchdog range

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_e;

endpackage

// File: rtl/apb_master.sv
// Single-outstanding APB requester: command in, SETUP/ACCESS bus phases, held response out.
// Define APB_MASTER_TIMEOUT_EN to enable the ACCESS-phase watchdog.
module apb_master
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic                  CMD_WRITE,
  input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
  input  logic [DATA_WIDTH-1:0] CMD_WDATA,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH-1:0] RSP_RDATA,
  output logic                  RSP_ERR,
  output logic                  RSP_TIMEOUT,
  output logic [ADDR_WIDTH-1:0] M_PADDR,
  output logic                  M_PSEL,
  output logic                  M_PENABLE,
  output logic                  M_PWRITE,
  output logic [DATA_WIDTH-1:0] M_PWDATA,
  input  logic                  M_PREADY,
  input  logic [DATA_WIDTH-1:0] M_PRDATA,
  input  logic                  M_PSLAVEERR
);

  apb_state_e            state_q, state_d;
  logic                  timeout_hit;
  logic                  access_done;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic                  pwrite_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;

  always_ff @(posedge PCLK) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (PRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign access_done = (state_q == ACCESS) && (M_PREADY || timeout_hit);

  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE:    if (CMD_VALID)   state_d = SETUP;
      SETUP:                    state_d = ACCESS;
      ACCESS:  if (access_done) state_d = RESP;
      RESP:    if (RSP_READY)   state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Command fields are frozen at accept, so the bus stays stable for the whole transfer.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && CMD_VALID) begin
        paddr_q  <= CMD_ADDR;
        pwrite_q <= CMD_WRITE;
        pwdata_q <= CMD_WDATA;
      end
      if (access_done) begin
        rsp_rdata_q <= (timeout_hit || pwrite_q) ? '0 : M_PRDATA;
        rsp_err_q   <= timeout_hit || (M_PREADY && M_PSLAVEERR);
      end
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [APB_TMO_CNT_W-1:0] TMO_LAST = APB_TMO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [APB_TMO_CNT_W-1:0] wait_cnt_q;
  logic                     rsp_timeout_q;

  // Counts stalled ACCESS cycles; the abort fires on the edge where it would reach the limit.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wait_cnt_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      if (state_q == SETUP)
        wait_cnt_q <= '0;
      else if (state_q == ACCESS && !M_PREADY)
        wait_cnt_q <= wait_cnt_q + APB_TMO_CNT_W'(1);
      if (access_done)
        rsp_timeout_q <= timeout_hit;
    end
  end

  assign timeout_hit = (state_q == ACCESS) && !M_PREADY && (wait_cnt_q == TMO_LAST);
  assign RSP_TIMEOUT = rsp_timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
  assign RSP_TIMEOUT        = 1'b0;
`endif

  assign CMD_READY = (state_q == IDLE) && !PRESET;
  assign M_PSEL    = (state_q == SETUP) || (state_q == ACCESS);
  assign M_PENABLE = (state_q == ACCESS);
  assign RSP_VALID = (state_q == RESP);
  assign M_PADDR   = paddr_q;
  assign M_PWRITE  = pwrite_q;
  assign M_PWDATA  = pwdata_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign RSP_ERR   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: transaction-level timing model plus directed vectors.
module tb_apb_master;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int TMO   = 4;
  localparam int NEVER = 100000;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          CMD_VALID = 1'b0;
  logic          CMD_WRITE = 1'b0;
  logic [AW-1:0] CMD_ADDR = '0;
  logic [DW-1:0] CMD_WDATA = '0;
  logic          RSP_READY = 1'b0;
  logic          CMD_READY, RSP_VALID, RSP_ERR, RSP_TIMEOUT;
  logic [DW-1:0] RSP_RDATA;
  logic [AW-1:0] M_PADDR;
  logic          M_PSEL, M_PENABLE, M_PWRITE;
  logic [DW-1:0] M_PWDATA;
  logic          M_PREADY, M_PSLAVEERR;
  logic [DW-1:0] M_PRDATA;

  int            slv_wait = 0;
  logic [DW-1:0] slv_rdata = '0;
  logic          slv_err = 1'b0;
  int            acc_cnt = 0;
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;

  apb_master #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .CMD_VALID  (CMD_VALID),
    .CMD_READY  (CMD_READY),
    .CMD_WRITE  (CMD_WRITE),
    .CMD_ADDR   (CMD_ADDR),
    .CMD_WDATA  (CMD_WDATA),
    .RSP_VALID  (RSP_VALID),
    .RSP_READY  (RSP_READY),
    .RSP_RDATA  (RSP_RDATA),
    .RSP_ERR    (RSP_ERR),
    .RSP_TIMEOUT(RSP_TIMEOUT),
    .M_PADDR    (M_PADDR),
    .M_PSEL     (M_PSEL),
    .M_PENABLE  (M_PENABLE),
    .M_PWRITE   (M_PWRITE),
    .M_PWDATA   (M_PWDATA),
    .M_PREADY   (M_PREADY),
    .M_PRDATA   (M_PRDATA),
    .M_PSLAVEERR(M_PSLAVEERR)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  // Completer: ready after slv_wait stalled ACCESS cycles.
  always @(posedge PCLK) acc_cnt <= (M_PENABLE && !M_PREADY) ? acc_cnt + 1 : 0;
  assign M_PREADY    = M_PENABLE && (acc_cnt == slv_wait);
  assign M_PRDATA    = slv_rdata;
  assign M_PSLAVEERR = slv_err;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Transaction model: one transfer at a time, phases derived from the accept cycle.
  logic          started = 1'b0;
  logic          m_busy = 1'b0;
  logic          m_fresh = 1'b1;
  int            m_acc = 0;
  int            m_nacc = 0;
  logic          m_write = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata = '0;
  logic          m_err = 1'b0;
  logic          m_to = 1'b0;

  initial forever begin
    int   d;
    logic e_ready, e_psel, e_pen, e_rspv, tmo;
    @(negedge PCLK);
    d       = cyc - m_acc;
    e_ready = !PRESET && !m_busy;
    e_psel  = m_busy && d >= 1 && (m_nacc < 0 || d <= 1 + m_nacc);
    e_pen   = m_busy && d >= 2 && (m_nacc < 0 || d <= 1 + m_nacc);
    e_rspv  = m_busy && m_nacc >= 0 && d >= 2 + m_nacc;
    if (started) begin
      check("cmd_ready", CMD_READY, e_ready);
      check("psel", M_PSEL, e_psel);
      check("penable", M_PENABLE, e_pen);
      check("rsp_valid", RSP_VALID, e_rspv);
      if (e_psel || m_fresh) begin
        check("paddr", M_PADDR, m_addr);
        check("pwrite", M_PWRITE, m_write);
        check("pwdata", M_PWDATA, m_wdata);
      end
      if (e_rspv || m_fresh) begin
        check("rsp_rdata", RSP_RDATA, m_rdata);
        check("rsp_err", RSP_ERR, m_err);
        check("rsp_timeout", RSP_TIMEOUT, m_to);
      end
    end
    if (PRESET) begin
      started = 1'b1;
      m_busy  = 1'b0;
      m_fresh = 1'b1;
      m_write = 1'b0;
      m_addr  = '0;
      m_wdata = '0;
      m_rdata = '0;
      m_err   = 1'b0;
      m_to    = 1'b0;
    end else if (started) begin
      if (e_ready && CMD_VALID) begin
        m_busy  = 1'b1;
        m_fresh = 1'b0;
        m_acc   = cyc;
        m_write = CMD_WRITE;
        m_addr  = CMD_ADDR;
        m_wdata = CMD_WDATA;
        tmo     = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
        tmo     = (slv_wait >= TMO);
`endif
        if (tmo) begin
          m_nacc  = TMO;
          m_to    = 1'b1;
          m_err   = 1'b1;
          m_rdata = '0;
        end else begin
          m_nacc  = (slv_wait >= NEVER) ? -1 : slv_wait + 1;
          m_to    = 1'b0;
          m_err   = slv_err;
          m_rdata = CMD_WRITE ? '0 : slv_rdata;
        end
      end else if (e_rspv && RSP_READY) begin
        m_busy = 1'b0;
      end
    end
  end

  task automatic start_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input int wait_n, input logic [DW-1:0] rdata, input logic err,
                           output int acc_n);
    @(posedge PCLK); #1;
    slv_wait  = wait_n;
    slv_rdata = rdata;
    slv_err   = err;
    CMD_VALID = 1'b1;
    CMD_WRITE = wr;
    CMD_ADDR  = addr;
    CMD_WDATA = wdata;
    acc_n = -1;
    for (int i = 0; i < 20 && acc_n < 0; i++) begin
      @(negedge PCLK);
      if (CMD_READY) acc_n = cyc;
    end
    @(posedge PCLK); #1;
    CMD_VALID = 1'b0;
    check("accept_seen", acc_n >= 0, 1'b1);
  endtask

  task automatic run_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input int wait_n, input logic [DW-1:0] rdata, input logic err,
                          input int hold, input logic junk,
                          output int acc_n, output int setup_n, output int access_n,
                          output int rsp_n, output int pen_cnt, output int held,
                          output logic [DW-1:0] r_rdata, output logic r_err, output logic r_to);
    start_cmd(wr, addr, wdata, wait_n, rdata, err, acc_n);
    setup_n = -1; access_n = -1; rsp_n = -1; pen_cnt = 0;
    r_rdata = '0; r_err = 1'b0; r_to = 1'b0;
    for (int i = 0; i < 200 && rsp_n < 0; i++) begin
      @(negedge PCLK);
      if (M_PSEL && !M_PENABLE && setup_n < 0) setup_n = cyc;
      if (M_PENABLE) begin
        pen_cnt++;
        if (access_n < 0) access_n = cyc;
      end
      if (RSP_VALID) begin
        rsp_n   = cyc;
        r_rdata = RSP_RDATA;
        r_err   = RSP_ERR;
        r_to    = RSP_TIMEOUT;
      end
    end
    check("rsp_seen", rsp_n >= 0, 1'b1);
    held = (rsp_n >= 0) ? 1 : 0;
    repeat (hold) begin
      @(posedge PCLK); #1;
      if (junk) begin
        CMD_VALID = 1'b1;
        CMD_ADDR  = 32'h0000_BAD0;
      end
      @(negedge PCLK);
      if (RSP_VALID) held++;
    end
    @(posedge PCLK); #1;
    RSP_READY = 1'b1;
    CMD_VALID = 1'b0;
    @(posedge PCLK); #1;
    RSP_READY = 1'b0;
  endtask

  task automatic reset_pulse();
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    @(negedge PCLK);
    check("midrst_cmd_ready_low", CMD_READY, 1'b0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(negedge PCLK);
    check("midrst_psel_low", M_PSEL, 1'b0);
    check("midrst_penable_low", M_PENABLE, 1'b0);
    check("midrst_rsp_valid_low", RSP_VALID, 1'b0);
    check("midrst_cmd_ready_high", CMD_READY, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int            acc_n, setup_n, access_n, rsp_n, pen_cnt, held, cnt;
    logic [DW-1:0] r_rdata;
    logic          r_err, r_to;

    PRESET = 1'b1;
    @(negedge PCLK);
    check("rst_cmd_ready", CMD_READY, 1'b0);
    check("rst_psel", M_PSEL, 1'b0);
    check("rst_rsp_valid", RSP_VALID, 1'b0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(negedge PCLK);
    check("post_rst_cmd_ready", CMD_READY, 1'b1);
    check("post_rst_paddr", M_PADDR, 32'h0);
    check("post_rst_rdata", RSP_RDATA, 32'h0);

    // Read, zero wait states.
    run_xfer(1'b0, 32'h0000_1004, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0,
             acc_n, setup_n, access_n, rsp_n, pen_cnt, held, r_rdata, r_err, r_to);
    check("rd_setup_cycle", setup_n, acc_n + 1);
    check("rd_access_cycle", access_n, acc_n + 2);
    check("rd_rsp_cycle", rsp_n, acc_n + 3);
    check("rd_rdata", r_rdata, 32'hDEAD_BEEF);
    check("rd_err", r_err, 1'b0);

    // Write, three wait states; completer drives junk PRDATA that must not leak.
    run_xfer(1'b1, 32'h0000_2000, 32'h1234_5678, 3, 32'hFFFF_0000, 1'b0, 0, 1'b0,
             acc_n, setup_n, access_n, rsp_n, pen_cnt, held, r_rdata, r_err, r_to);
    check("wr_penable_cycles", pen_cnt, 4);
    check("wr_rsp_cycle", rsp_n, acc_n + 6);
    check("wr_rdata_zero", r_rdata, 32'h0);
    check("wr_err", r_err, 1'b0);

    // Slave error, response held while RSP_READY low, new commands ignored meanwhile.
    run_xfer(1'b0, 32'h0000_3008, 32'h0, 1, 32'hCAFE_0001, 1'b1, 4, 1'b1,
             acc_n, setup_n, access_n, rsp_n, pen_cnt, held, r_rdata, r_err, r_to);
    check("slverr_err", r_err, 1'b1);
    check("slverr_timeout", r_to, 1'b0);
    check("slverr_held_cycles", held, 5);

`ifdef APB_MASTER_TIMEOUT_EN
    run_xfer(1'b0, 32'h0000_4000, 32'h0, NEVER, 32'hA5A5_A5A5, 1'b0, 0, 1'b0,
             acc_n, setup_n, access_n, rsp_n, pen_cnt, held, r_rdata, r_err, r_to);
    check("tmo_penable_cycles", pen_cnt, TMO);
    check("tmo_rsp_cycle", rsp_n, acc_n + 2 + TMO);
    check("tmo_err", r_err, 1'b1);
    check("tmo_flag", r_to, 1'b1);
    check("tmo_rdata_zero", r_rdata, 32'h0);

    start_cmd(1'b0, 32'h0000_5000, 32'h0, NEVER, 32'h1111_2222, 1'b0, acc_n);
    cnt = 0;
    while (!M_PENABLE && cnt < 20) begin
      @(negedge PCLK);
      cnt++;
    end
    check("access_reached", M_PENABLE, 1'b1);
    reset_pulse();
`else
    start_cmd(1'b0, 32'h0000_4000, 32'h0, NEVER, 32'hA5A5_A5A5, 1'b0, acc_n);
    cnt = 0;
    repeat (100) begin
      @(negedge PCLK);
      if (RSP_VALID) cnt++;
    end
    check("no_rsp_100_cycles", cnt, 0);
    check("psel_still_high", M_PSEL, 1'b1);
    reset_pulse();
`endif

    // Recovery after the mid-transfer reset.
    run_xfer(1'b0, 32'h0000_6010, 32'h0, 2, 32'h0BAD_F00D, 1'b0, 0, 1'b0,
             acc_n, setup_n, access_n, rsp_n, pen_cnt, held, r_rdata, r_err, r_to);
    check("recov_rsp_cycle", rsp_n, acc_n + 5);
    check("recov_rdata", r_rdata, 32'h0BAD_F00D);

    repeat (3) @(negedge PCLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
